// File: rtl/pipe_ctrl_unit_if.sv
// Bus between the pipeline controller and its clients: stall requests and flush
// requests in; the stall vector, flush/redirect and watchdog/performance status out.
interface pipe_ctrl_unit_if #(
  parameter int NUM_STAGES = 6,
  parameter int CNT_W      = 32
);
  logic [NUM_STAGES-1:0] stallreq;
  logic                  flush_req;
  logic [31:0]           flush_pc;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [31:0]           new_pc;
  logic                  stall_timeout;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: combinational prefix stall mask (0 cycles), registered flush/redirect
// (1 cycle after flush_req), sticky stall watchdog and saturating stall-cycle counter.
module pipe_ctrl_unit #(
  parameter int NUM_STAGES    = 6,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_ctrl_unit_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  localparam int              WD_W     = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
  localparam bit              WD_EN    = (STALL_TIMEOUT > 0);

  logic [0:0]            state;
  logic [FC_W-1:0]       fcnt;
  logic [31:0]           pc_q;
  logic [WD_W-1:0]       wd;
  logic                  to_q;
  logic [CNT_W-1:0]      cyc;
  logic [NUM_STAGES-1:0] mask;
  logic [NUM_STAGES-1:0] stall_v;
  logic                  stall_any;

  // Stage i holds whenever it or any later stage requests a hold.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      mask[i] = |(bus.stallreq >> i);
    end
  end

  assign stall_v   = (rst || state == FLUSH) ? '0 : mask;
  assign stall_any = |stall_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
      pc_q  <= '0;
      wd    <= '0;
      to_q  <= 1'b0;
      cyc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state <= FLUSH;
            pc_q  <= bus.flush_pc;
            fcnt  <= FC_LOAD;
          end
        end
        default: begin
          // A new redirect during a flush replaces the pending one and restarts the window.
          if (bus.flush_req) begin
            pc_q <= bus.flush_pc;
            fcnt <= FC_LOAD;
          end else if (fcnt == '0) begin
            state <= IDLE;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
      endcase

      if (stall_any) begin
        if (wd != WD_LIMIT) begin
          wd <= wd + 1'b1;
        end
        if (WD_EN && wd == WD_LAST) begin
          to_q <= 1'b1;
        end
      end else begin
        wd <= '0;
      end

      if (stall_any && cyc != '1) begin
        cyc <= cyc + 1'b1;
      end
    end
  end

  assign bus.stall         = stall_v;
  assign bus.flush         = (state == FLUSH);
  assign bus.new_pc        = pc_q;
  assign bus.stall_timeout = to_q;
  assign bus.stall_cycles  = cyc;
endmodule
